disp_timing_gen: RTL and testbench

DISP_TIMING_GEN -- requirements
Module: disp_timing_gen

---
 rtl/disp_pkg.sv | 41 ++++
 rtl/disp_hv_cnt.sv | 64 ++++++
 rtl/disp_timing_gen.sv | 211 +++++++++++++++++++++
 tb/tb_disp_timing_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display timing generator.
// Holds the controller state enum, the RGB888 pixel type and the
// colour-bar palette used by the optional test-pattern generator.
package disp_pkg;

    // Controller states: IDLE (counters parked), RUN (streaming), STOP (draining the frame)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } disp_state_e;

    localparam int unsigned PIX_W = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    // Eight-bar palette, left to right, in RGB888
    localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
    localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
    localparam pixel_t BAR_CYAN    = 24'h00FFFF;
    localparam pixel_t BAR_GREEN   = 24'h00FF00;
    localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
    localparam pixel_t BAR_RED     = 24'hFF0000;
    localparam pixel_t BAR_BLUE    = 24'h0000FF;
    localparam pixel_t BAR_BLACK   = 24'h000000;

    // Map a bar index 0..7 onto its palette colour
    function automatic pixel_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = BAR_WHITE;
            3'd1:    bar_colour = BAR_YELLOW;
            3'd2:    bar_colour = BAR_CYAN;
            3'd3:    bar_colour = BAR_GREEN;
            3'd4:    bar_colour = BAR_MAGENTA;
            3'd5:    bar_colour = BAR_RED;
            3'd6:    bar_colour = BAR_BLUE;
            default: bar_colour = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/disp_hv_cnt.sv
// disp_hv_cnt: horizontal/vertical raster counter pair.
// While run_i is low both counters are held at zero, so the first running
// clock presents position (0,0). line_end / frame_end flag the last clock
// of a line and of a frame respectively.
module disp_hv_cnt #(
    parameter int unsigned HT = 800,
    parameter int unsigned VT = 525,
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_end,
    output logic          frame_end
);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

    logic [HW-1:0] h_q;
    logic [HW-1:0] h_d;
    logic [VW-1:0] v_q;
    logic [VW-1:0] v_d;

    assign h_cnt     = h_q;
    assign v_cnt     = v_q;
    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

    // Next raster position: park at origin when stopped, else advance and wrap
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = HW'(0);
            v_d = VW'(0);
        end else if (line_end) begin
            h_d = HW'(0);
            if (v_q == V_LAST) begin
                v_d = VW'(0);
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
            v_d = v_q;
        end
    end

    // Raster position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= HW'(0);
            v_q <= VW'(0);
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

endmodule

// File: rtl/disp_timing_gen.sv
// disp_timing_gen: parameterised raster timing generator for a parallel
// RGB display bus. Produces HSYNC/VSYNC/DATA_ENABLE/DATA one clock after the
// raster position they describe, pulls pixels from a valid/ready source and
// records starvation in a sticky underflow flag. Dropping en lets the current
// frame finish before returning to idle.
// Build option: define DISP_TPG_EN to add the tpg_sel input and an eight-bar
// colour test pattern that replaces the pixel source while selected.
module disp_timing_gen
    import disp_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr_uflow,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
`ifdef DISP_TPG_EN
    input  logic        tpg_sel,
`endif
    output logic        pix_ready,
    output logic        VSYNC,
    output logic        HSYNC,
    output logic        DATA_ENABLE,
    output logic [23:0] DATA,
    output logic        frame_start,
    output logic        busy,
    output logic        uflow
);

    localparam int unsigned HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // One spare bit so the end-of-active bound never aliases to zero
    localparam int unsigned HW = $clog2(HT + 1);
    localparam int unsigned VW = $clog2(VT + 1);

    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);

    disp_state_e   state_q;
    disp_state_e   state_d;

    logic [HW-1:0] h_cnt_s;
    logic [VW-1:0] v_cnt_s;
    logic          line_end_s;
    logic          frame_end_s;

    logic          busy_s;
    logic          active_s;
    logic          uflow_set_s;

    logic          hsync_q;
    logic          hsync_d;
    logic          vsync_q;
    logic          vsync_d;
    logic          de_q;
    logic          de_d;
    pixel_t        data_q;
    pixel_t        data_d;
    logic          fs_q;
    logic          fs_d;
    logic          uflow_q;
    logic          uflow_d;

`ifdef DISP_TPG_EN
    logic [HW-1:0] tpg_col_s;
    logic [2:0]    tpg_bar_s;
`endif

    assign busy_s = (state_q != ST_IDLE);

    disp_hv_cnt #(
        .HT (HT),
        .VT (VT),
        .HW (HW),
        .VW (VW)
    ) u_hv_cnt (
        .clk       (clk),
        .rst       (rst),
        .run_i     (busy_s),
        .h_cnt     (h_cnt_s),
        .v_cnt     (v_cnt_s),
        .line_end  (line_end_s),
        .frame_end (frame_end_s)
    );

    // Controller next state; STOP drains to the last clock of the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (line_end_s && frame_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign active_s = busy_s
                   && (h_cnt_s >= H_ACT_BEG) && (h_cnt_s < H_ACT_END)
                   && (v_cnt_s >= V_ACT_BEG) && (v_cnt_s < V_ACT_END);

`ifdef DISP_TPG_EN
    assign tpg_col_s = h_cnt_s - H_ACT_BEG;
    assign tpg_bar_s = 3'({tpg_col_s, 3'b000} / (HW + 3)'(H_ACTIVE));
    // The pattern generator replaces the source, so nothing is consumed while it runs
    assign pix_ready = active_s && !tpg_sel;
`else
    assign pix_ready = active_s;
`endif

    // Next values of the registered display bus and the sticky underflow flag
    always_comb begin
        hsync_d     = (busy_s && (h_cnt_s < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d     = (busy_s && (v_cnt_s < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        de_d        = active_s;
        fs_d        = busy_s && (h_cnt_s == HW'(0)) && (v_cnt_s == VW'(0));
        data_d      = BAR_BLACK;
        uflow_set_s = 1'b0;
`ifdef DISP_TPG_EN
        if (active_s && tpg_sel) begin
            data_d = bar_colour(tpg_bar_s);
        end else
`endif
        if (active_s && pix_valid) begin
            data_d = pix_data;
        end else if (active_s) begin
            data_d      = 24'h000000;
            uflow_set_s = 1'b1;
        end else begin
            data_d = 24'h000000;
        end
        // A fresh underflow wins over a clear arriving in the same clock
        if (uflow_set_s) begin
            uflow_d = 1'b1;
        end else if (clr_uflow) begin
            uflow_d = 1'b0;
        end else begin
            uflow_d = uflow_q;
        end
    end

    // Output registers for the display bus and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            data_q  <= 24'h000000;
            fs_q    <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            data_q  <= data_d;
            fs_q    <= fs_d;
            uflow_q <= uflow_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DATA_ENABLE = de_q;
    assign DATA        = data_q;
    assign frame_start = fs_q;
    assign uflow       = uflow_q;
    assign busy        = busy_s;

endmodule

// File: tb/tb_disp_timing_gen.sv
// tb_disp_timing_gen: directed bench for disp_timing_gen with a tiny raster
// (HT=8: sync 0-1, bp 2, active 3-6, fp 7; VT=6: sync 0, bp 1, active 2-4, fp 5).
// Inputs change and outputs are sampled on the falling edge; outputs lag
// the raster position by one clock.
module tb_disp_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_uflow;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        VSYNC;
    logic        HSYNC;
    logic        DATA_ENABLE;
    logic [23:0] DATA;
    logic        frame_start;
    logic        busy;
    logic        uflow;
`ifdef DISP_TPG_EN
    logic        tpg_sel;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    disp_timing_gen #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr_uflow   (clr_uflow),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
`ifdef DISP_TPG_EN
        .tpg_sel     (tpg_sel),
`endif
        .pix_ready   (pix_ready),
        .VSYNC       (VSYNC),
        .HSYNC       (HSYNC),
        .DATA_ENABLE (DATA_ENABLE),
        .DATA        (DATA),
        .frame_start (frame_start),
        .busy        (busy),
        .uflow       (uflow)
    );

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        clr_uflow = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 24'h0;
`ifdef DISP_TPG_EN
        tpg_sel   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en        = 1'b1;
        clr_uflow = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 24'h777777;
`ifdef DISP_TPG_EN
        tpg_sel   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        tests_run++;
        if ({HSYNC, VSYNC, DATA_ENABLE, frame_start, uflow, pix_ready, busy} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {HSYNC, VSYNC, DATA_ENABLE, frame_start, uflow, pix_ready, busy});
        end
        tests_run++;
        if (DATA !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 000000", DATA);
        end
        do_reset();
        tests_run++;
        if ({HSYNC, VSYNC, DATA_ENABLE, frame_start, busy} !== 5'b0) begin
            tests_failed++;
            $display("FAIL idle_flags: got %b expected 00000",
                     {HSYNC, VSYNC, DATA_ENABLE, frame_start, busy});
        end
    endtask

    task automatic test_timing();
        int hs = 0, vs = 0, de = 0, fs = 0, rdy = 0;
        int hs_pos = 0, vs_pos = 0, fs_pos = 0;
        do_reset();
        pix_valid = 1'b1;
        pix_data  = 24'h5A5A5A;
        en        = 1'b1;
        for (int i = 0; i <= 96; i++) begin
            @(negedge clk);
            if (i < 96 && pix_ready) rdy++;
            if (i >= 1) begin
                if (HSYNC) hs++;
                if (VSYNC) vs++;
                if (DATA_ENABLE) de++;
                if (frame_start) fs++;
                if (HSYNC !== (((i - 1) % 8) < 2)) hs_pos++;
                if (VSYNC !== (((i - 1) % 48) < 8)) vs_pos++;
                if (frame_start !== (((i - 1) % 48) == 0)) fs_pos++;
            end
        end
        tests_run++;
        if (hs != 24) begin tests_failed++; $display("FAIL hsync_count: got %0d expected 24", hs); end
        tests_run++;
        if (vs != 16) begin tests_failed++; $display("FAIL vsync_count: got %0d expected 16", vs); end
        tests_run++;
        if (de != 24) begin tests_failed++; $display("FAIL de_count: got %0d expected 24", de); end
        tests_run++;
        if (fs != 2) begin tests_failed++; $display("FAIL frame_start_count: got %0d expected 2", fs); end
        tests_run++;
        if (rdy != 24) begin tests_failed++; $display("FAIL ready_count: got %0d expected 24", rdy); end
        tests_run++;
        if (hs_pos != 0) begin tests_failed++; $display("FAIL hsync_position: got %0d bad clocks expected 0", hs_pos); end
        tests_run++;
        if (vs_pos != 0) begin tests_failed++; $display("FAIL vsync_position: got %0d bad clocks expected 0", vs_pos); end
        tests_run++;
        if (fs_pos != 0) begin tests_failed++; $display("FAIL frame_start_position: got %0d bad clocks expected 0", fs_pos); end
    endtask

    task automatic test_data();
        logic [23:0] exp_px = 24'h1;
        logic        prev_rdy = 1'b0;
        do_reset();
        pix_valid = 1'b1;
        pix_data  = 24'h1;
        en        = 1'b1;
        for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            if (DATA_ENABLE) begin
                tests_run++;
                if (DATA !== exp_px || !prev_rdy) begin
                    tests_failed++;
                    $display("FAIL data_seq: clk %0d got %h ready_before=%b expected %h ready_before=1",
                             i, DATA, prev_rdy, exp_px);
                end
                exp_px = exp_px + 24'h1;
            end else begin
                tests_run++;
                if (DATA !== 24'h0) begin
                    tests_failed++;
                    $display("FAIL data_blank: clk %0d got %h expected 000000", i, DATA);
                end
            end
            if (prev_rdy) pix_data = pix_data + 24'h1;
            prev_rdy = pix_ready;
        end
        tests_run++;
        if (exp_px !== 24'hD) begin
            tests_failed++;
            $display("FAIL data_count: got %0d pixels expected 12", exp_px - 24'h1);
        end
    endtask

    task automatic test_uflow();
        bit found = 1'b0;
        do_reset();
        pix_valid = 1'b1;
        pix_data  = 24'hABCDEF;
        en        = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (pix_ready) found = 1'b1;
        end
        tests_run++;
        if (!found || uflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL uflow_pre: ready_seen=%b uflow=%b expected ready_seen=1 uflow=0", found, uflow);
        end
        pix_valid = 1'b0;
        @(negedge clk);
        pix_valid = 1'b1;
        tests_run++;
        if ({DATA_ENABLE, uflow} !== 2'b11 || DATA !== 24'h0) begin
            tests_failed++;
            $display("FAIL uflow_set: de=%b uflow=%b data=%h expected de=1 uflow=1 data=000000",
                     DATA_ENABLE, uflow, DATA);
        end
        @(negedge clk);
        tests_run++;
        if (DATA !== 24'hABCDEF || uflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL uflow_recover: data=%h uflow=%b expected data=abcdef uflow=1", DATA, uflow);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (uflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL uflow_sticky: got %b expected 1", uflow);
        end
        clr_uflow = 1'b1;
        @(negedge clk);
        clr_uflow = 1'b0;
        tests_run++;
        if (uflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL uflow_clear: got %b expected 0", uflow);
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (pix_ready) found = 1'b1;
        end
        tests_run++;
        if (!found || uflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL uflow_wait2: ready_seen=%b uflow=%b expected ready_seen=1 uflow=0", found, uflow);
        end
        pix_valid = 1'b0;
        clr_uflow = 1'b1;
        @(negedge clk);
        pix_valid = 1'b1;
        clr_uflow = 1'b0;
        tests_run++;
        if (uflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL uflow_clr_collide: got %b expected 1", uflow);
        end
    endtask

    task automatic test_stop();
        int de = 0;
        do_reset();
        pix_valid = 1'b1;
        pix_data  = 24'h123456;
        en        = 1'b1;
        for (int i = 0; i <= 52; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 48 && DATA_ENABLE) de++;
            if (i == 10) en = 1'b0;
            if (i == 47) begin
                tests_run++;
                if (busy !== 1'b1) begin tests_failed++; $display("FAIL stop_busy_last: got %b expected 1", busy); end
            end
            if (i == 48) begin
                tests_run++;
                if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy_fall: got %b expected 0", busy); end
            end
            if (i >= 49) begin
                tests_run++;
                if ({HSYNC, VSYNC, DATA_ENABLE, frame_start, pix_ready, busy} !== 6'b0 || DATA !== 24'h0) begin
                    tests_failed++;
                    $display("FAIL stop_idle: clk %0d flags=%b data=%h expected flags=000000 data=000000",
                             i, {HSYNC, VSYNC, DATA_ENABLE, frame_start, pix_ready, busy}, DATA);
                end
            end
        end
        tests_run++;
        if (de != 12) begin tests_failed++; $display("FAIL stop_frame_de: got %0d expected 12", de); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        pix_valid = 1'b1;
        pix_data  = 24'h00FF00;
        en        = 1'b1;
        repeat (21) @(negedge clk);
        tests_run++;
        if (DATA_ENABLE !== 1'b1 || DATA !== 24'h00FF00) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: de=%b data=%h expected de=1 data=00ff00", DATA_ENABLE, DATA);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({HSYNC, VSYNC, DATA_ENABLE, frame_start, uflow, pix_ready, busy} !== 7'b0 || DATA !== 24'h0) begin
            tests_failed++;
            $display("FAIL rst_async: flags=%b data=%h expected flags=0000000 data=000000",
                     {HSYNC, VSYNC, DATA_ENABLE, frame_start, uflow, pix_ready, busy}, DATA);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tests_run++;
                if (busy !== 1'b1 || frame_start !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL restart_0: busy=%b fs=%b expected busy=1 fs=0", busy, frame_start);
                end
            end
            if (i == 1) begin
                tests_run++;
                if ({frame_start, HSYNC, VSYNC} !== 3'b111) begin
                    tests_failed++;
                    $display("FAIL restart_origin: fs/hs/vs=%b expected 111", {frame_start, HSYNC, VSYNC});
                end
            end
            if (i == 3) begin
                tests_run++;
                if (HSYNC !== 1'b0 || frame_start !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL restart_hsync_end: hs=%b fs=%b expected hs=0 fs=0", HSYNC, frame_start);
                end
            end
        end
    endtask

`ifdef DISP_TPG_EN
    task automatic test_tpg();
        logic [23:0] bars [4];
        int de = 0;
        bars[0] = 24'hFFFFFF;
        bars[1] = 24'h00FFFF;
        bars[2] = 24'hFF00FF;
        bars[3] = 24'h0000FF;
        do_reset();
        tpg_sel   = 1'b1;
        pix_valid = 1'b0;
        en        = 1'b1;
        for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            tests_run++;
            if (pix_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL tpg_ready: clk %0d got %b expected 0", i, pix_ready);
            end
            if (i >= 1 && DATA_ENABLE) begin
                tests_run++;
                if (DATA !== bars[de % 4]) begin
                    tests_failed++;
                    $display("FAIL tpg_bar: col %0d got %h expected %h", de % 4, DATA, bars[de % 4]);
                end
                de++;
            end
        end
        tests_run++;
        if (de != 12 || uflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL tpg_frame: de=%0d uflow=%b expected de=12 uflow=0", de, uflow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_data();
        test_uflow();
        test_stop();
        test_rst_mid();
`ifdef DISP_TPG_EN
        test_tpg();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
